seq_stim_gen: RTL and testbench

SEQ_STIM_GEN -- requirements
Module: seq_stim_gen

---
 rtl/seq_stim_pkg.sv | 19 +
 rtl/seq_stim_chan.sv | 60 ++++++
 rtl/seq_stim_gen.sv | 101 ++++++++++
 tb/tb_seq_stim_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_stim_pkg.sv
// Shared definitions for the sequenced x/y stimulus generator: default sizing,
// counter width derivation and the launch FSM state encoding.
package seq_stim_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_MAX_DLY = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Width of one per-channel spacing field; must be able to hold max_dly.
    function automatic int dly_width(input int max_dly);
        return $clog2(max_dly + 1);
    endfunction

endpackage

// File: rtl/seq_stim_chan.sv
// One x/y channel: latches its spacing at launch, emits x immediately and y
// when its down-counter runs out, and reports when the counter has expired.
module seq_stim_chan
    import seq_stim_pkg::*;
#(
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int DLY_W   = dly_width(MAX_DLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_run,
    input  logic             i_en,
    input  logic             i_kill,
    input  logic [DLY_W-1:0] i_dly,
    output logic             o_x,
    output logic             o_y,
    output logic             o_expired
);

    logic [DLY_W:0]   w_dly_ext;
    logic [DLY_W-1:0] w_dly_clamp;
    logic [DLY_W-1:0] r_cnt;
    logic             r_kill;
    logic             r_x;
    logic             r_y;

    // Compare one bit wider so the test stays meaningful when MAX_DLY fills the field.
    assign w_dly_ext   = {1'b0, i_dly};
    assign w_dly_clamp = (w_dly_ext > (DLY_W+1)'(MAX_DLY)) ? DLY_W'(MAX_DLY) : i_dly;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values and the block order never changes behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_kill <= 1'b0;
            r_x    <= 1'b0;
            r_y    <= 1'b0;
        end else if (i_load) begin
            r_kill <= i_kill;
            r_x    <= i_en;
            r_y    <= i_en & ~i_kill & (w_dly_clamp == '0);
            r_cnt  <= i_en ? w_dly_clamp : '0;
        end else begin
            r_x <= 1'b0;
            if (i_run && (r_cnt != '0)) begin
                r_cnt <= r_cnt - DLY_W'(1);
                r_y   <= (r_cnt == DLY_W'(1)) & ~r_kill;
            end else begin
                r_y <= 1'b0;
            end
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/seq_stim_gen.sv
// Launch sequencer: one start fires x on every enabled channel, then y after each
// channel's spacing; busy/done frame the launch and start_err flags rejected starts.
module seq_stim_gen
    import seq_stim_pkg::*;
#(
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int MAX_DLY = DEF_MAX_DLY,
    localparam int DLY_W   = dly_width(MAX_DLY)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH*DLY_W-1:0] dly,
    input  logic [NUM_CH-1:0]       en_ch,
    input  logic [NUM_CH-1:0]       y_kill,
    output logic [NUM_CH-1:0]       x,
    output logic [NUM_CH-1:0]       y,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err
);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_start_err;
    logic              w_launch;
    logic              w_run;
    logic [NUM_CH-1:0] w_expired;

    assign w_launch = start && (r_state == IDLE);
    assign w_run    = (r_state == RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            seq_stim_chan #(
                .MAX_DLY (MAX_DLY),
                .DLY_W   (DLY_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_load    (w_launch),
                .i_run     (w_run),
                .i_en      (en_ch[gi]),
                .i_kill    (y_kill[gi]),
                .i_dly     (dly[gi*DLY_W +: DLY_W]),
                .o_x       (x[gi]),
                .o_y       (y[gi]),
                .o_expired (w_expired[gi])
            );
        end
    endgenerate

    // Disabled channels load a zero count, so they always read as expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_start_err <= start && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        // With nothing enabled the launch finishes in its first cycle.
                        if (|en_ch) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (&w_expired) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign start_err = r_start_err;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench for seq_stim_gen: each launch expands into a per-cycle expected
// trace that is queued up front and popped one entry per clock against the outputs.
module tb_seq_stim_gen;

    localparam int NUM_CH  = 4;
    localparam int MAX_DLY = 7;
    localparam int DLY_W   = 3;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [NUM_CH*DLY_W-1:0] dly;
    logic [NUM_CH-1:0]       en_ch;
    logic [NUM_CH-1:0]       y_kill;
    logic [NUM_CH-1:0]       x;
    logic [NUM_CH-1:0]       y;
    logic                    busy;
    logic                    done;
    logic                    start_err;

    // Single-channel instance whose MAX_DLY does not fill its 3-bit field.
    logic       c_start;
    logic [2:0] c_dly;
    logic [0:0] c_en;
    logic [0:0] c_kill;
    logic [0:0] c_x;
    logic [0:0] c_y;
    logic       c_busy;
    logic       c_done;
    logic       c_err;

    obs_t sb_q[$];
    obs_t plan[0:63];
    obs_t obs;
    obs_t exp_o;
    int   n_checks;
    int   n_errors;

    seq_stim_gen #(.NUM_CH(NUM_CH), .MAX_DLY(MAX_DLY)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dly       (dly),
        .en_ch     (en_ch),
        .y_kill    (y_kill),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .start_err (start_err)
    );

    seq_stim_gen #(.NUM_CH(1), .MAX_DLY(5)) u_clamp (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (c_start),
        .dly       (c_dly),
        .en_ch     (c_en),
        .y_kill    (c_kill),
        .x         (c_x),
        .y         (c_y),
        .busy      (c_busy),
        .done      (c_done),
        .start_err (c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%b y=%b busy=%b done=%b err=%b", o.x, o.y, o.busy, o.done, o.err);
    endfunction

    function automatic logic [11:0] pack_dly(input int d0, input int d1, input int d2, input int d3);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic void clear_plan();
        for (int j = 0; j < 64; j++) plan[j] = '0;
    endfunction

    // Entry base+j of the plan is what the outputs hold after the j-th edge past launch.
    function automatic void add_launch(input int base, input logic [3:0] en, input logic [3:0] kill,
                                       input logic [11:0] dv, input int maxd);
        int d[4];
        int dmax;
        dmax = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(dv[i*3 +: 3]);
            if (d[i] > maxd) d[i] = maxd;
            if (en[i] && d[i] > dmax) dmax = d[i];
        end
        plan[base+1].x |= en;
        for (int i = 0; i < 4; i++)
            if (en[i] && !kill[i]) plan[base+1+d[i]].y[i] = 1'b1;
        if (en == 4'b0000) begin
            plan[base+1].busy = 1'b1;
            plan[base+1].done = 1'b1;
        end else begin
            for (int j = 1; j <= 2 + dmax; j++) plan[base+j].busy = 1'b1;
            plan[base+2+dmax].done = 1'b1;
        end
    endfunction

    function automatic void push_plan(input int n);
        for (int j = 1; j <= n; j++) sb_q.push_back(plan[j]);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        obs = {x, y, busy, done, start_err};
        n_checks++;
        if (obs !== obs_t'('0)) begin
            n_errors++;
            $display("FAIL reset_state: got %s, want all zero", fmt(obs));
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {x, y, busy, done, start_err};
        n_checks++;
        if (obs !== obs_t'('0)) begin
            n_errors++;
            $display("FAIL reset_release: got %s, want all zero", fmt(obs));
        end
    endtask

    task automatic test_basic();
        clear_plan();
        add_launch(0, 4'b0111, 4'b0000, pack_dly(1, 2, 3, 5), MAX_DLY);
        push_plan(7);
        en_ch = 4'b0111; y_kill = 4'b0000; dly = pack_dly(1, 2, 3, 5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            if (j == 1) begin
                en_ch = 4'b1111; y_kill = 4'b1111; dly = '0;
            end
            exp_o = sb_q.pop_front();
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL basic k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
        y_kill = 4'b0000;
    endtask

    task automatic test_y_kill();
        clear_plan();
        add_launch(0, 4'b0011, 4'b0010, pack_dly(1, 1, 0, 0), MAX_DLY);
        push_plan(5);
        en_ch = 4'b0011; y_kill = 4'b0010; dly = pack_dly(1, 1, 0, 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            exp_o = sb_q.pop_front();
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL y_kill k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
        y_kill = 4'b0000;
    endtask

    // The 3-bit field cannot carry 15, so ch1 receives the largest legal code, 7.
    task automatic test_dly_extremes();
        clear_plan();
        add_launch(0, 4'b0011, 4'b0000, pack_dly(0, 7, 0, 0), MAX_DLY);
        push_plan(11);
        en_ch = 4'b0011; dly = pack_dly(0, 7, 0, 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            exp_o = sb_q.pop_front();
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL dly_extremes k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        clear_plan();
        add_launch(0, 4'b0001, 4'b0000, pack_dly(4, 0, 0, 0), MAX_DLY);
        add_launch(7, 4'b0010, 4'b0000, pack_dly(0, 2, 0, 0), MAX_DLY);
        plan[2].err = 1'b1;
        plan[3].err = 1'b1;
        plan[7].err = 1'b1;
        push_plan(13);
        en_ch = 4'b0001; dly = pack_dly(4, 0, 0, 0); start = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 13; j++) begin
            case (j)
                3:       start = 1'b0;
                6: begin
                    start = 1'b1; en_ch = 4'b0010; dly = pack_dly(0, 2, 0, 0);
                end
                8:       start = 1'b0;
                default: ;
            endcase
            exp_o = sb_q.pop_front();
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL back_to_back k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_enable();
        clear_plan();
        add_launch(0, 4'b0000, 4'b0000, pack_dly(3, 3, 3, 3), MAX_DLY);
        plan[2].err = 1'b1;
        push_plan(4);
        en_ch = 4'b0000; dly = pack_dly(3, 3, 3, 3); start = 1'b1;
        @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            if (j == 2) start = 1'b0;
            exp_o = sb_q.pop_front();
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL no_enable k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        clear_plan();
        add_launch(0, 4'b0011, 4'b0000, pack_dly(3, 5, 0, 0), MAX_DLY);
        push_plan(1);
        en_ch = 4'b0011; dly = pack_dly(3, 5, 0, 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_o = sb_q.pop_front();
        obs = {x, y, busy, done, start_err};
        n_checks++;
        if (obs !== exp_o) begin
            n_errors++;
            $display("FAIL abort_pre k+1: got %s, want %s", fmt(obs), fmt(exp_o));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== obs_t'('0)) begin
                n_errors++;
                $display("FAIL abort_in_reset step %0d: got %s, want all zero", j, fmt(obs));
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {x, y, busy, done, start_err};
        n_checks++;
        if (obs !== obs_t'('0)) begin
            n_errors++;
            $display("FAIL abort_after_release: got %s, want all zero", fmt(obs));
        end
        clear_plan();
        add_launch(0, 4'b0001, 4'b0000, pack_dly(2, 0, 0, 0), MAX_DLY);
        push_plan(5);
        en_ch = 4'b0001; dly = pack_dly(2, 0, 0, 0); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            exp_o = sb_q.pop_front();
            obs = {x, y, busy, done, start_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL relaunch k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        clear_plan();
        add_launch(0, 4'b0001, 4'b0000, pack_dly(7, 0, 0, 0), 5);
        push_plan(9);
        c_en = 1'b1; c_kill = 1'b0; c_dly = 3'd7; c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            exp_o = sb_q.pop_front();
            obs = {3'b000, c_x, 3'b000, c_y, c_busy, c_done, c_err};
            n_checks++;
            if (obs !== exp_o) begin
                n_errors++;
                $display("FAIL clamp k+%0d: got %s, want %s", j, fmt(obs), fmt(exp_o));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dly      = '0;
        en_ch    = '0;
        y_kill   = '0;
        c_start  = 1'b0;
        c_dly    = '0;
        c_en     = '0;
        c_kill   = '0;
        test_reset();
        test_basic();
        test_y_kill();
        test_dly_extremes();
        test_back_to_back();
        test_no_enable();
        test_reset_abort();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
